// File: rtl/fiber_mshr.sv
// Miss-status holding register file: merges bank misses per line, issues one DRAM
// read per line, and returns each filled line to the bank with its waiter count.
module fiber_mshr #(
   parameter int unsigned ADDR_WIDTH = 64,
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned ENTRIES    = 4,
   parameter int unsigned MERGE_BITS = 3
) (
   input  logic                            i_clk,
   input  logic                            i_reset,
   input  logic [ADDR_WIDTH-1:0]           i_miss_addr,
   input  logic                            i_miss_valid,
   output logic                            o_miss_ready,
   output logic [$clog2(ENTRIES)-1:0]      o_miss_id,
   output logic                            o_miss_merged,
   output logic [ADDR_WIDTH-1:0]           o_dram_addr,
   output logic [$clog2(ENTRIES)-1:0]      o_dram_id,
   output logic                            o_dram_req_valid,
   input  logic                            i_dram_req_ready,
   input  logic [DATA_WIDTH-1:0]           i_dram_data,
   input  logic [$clog2(ENTRIES)-1:0]      i_dram_rid,
   input  logic                            i_dram_rsp_valid,
   output logic                            o_dram_rsp_ready,
   output logic [ADDR_WIDTH-1:0]           o_fill_addr,
   output logic [DATA_WIDTH-1:0]           o_fill_data,
   output logic [MERGE_BITS-1:0]           o_fill_count,
   output logic                            o_fill_valid,
   input  logic                            i_fill_ready
);

   localparam int unsigned IDW = $clog2(ENTRIES);
   localparam logic [MERGE_BITS-1:0] CNT_MAX = '1;

   typedef enum logic [1:0] {
      S_FREE   = 2'd0,
      S_PEND   = 2'd1,
      S_ISSUED = 2'd2,
      S_FILL   = 2'd3
   } ent_st_e;

   ent_st_e                 st_q   [ENTRIES];
   ent_st_e                 st_d   [ENTRIES];
   logic [ADDR_WIDTH-1:0]   addr_q [ENTRIES];
   logic [ADDR_WIDTH-1:0]   addr_d [ENTRIES];
   logic [DATA_WIDTH-1:0]   data_q [ENTRIES];
   logic [DATA_WIDTH-1:0]   data_d [ENTRIES];
   logic [MERGE_BITS-1:0]   cnt_q  [ENTRIES];
   logic [MERGE_BITS-1:0]   cnt_d  [ENTRIES];

   logic            hit, fill_hit, free_any, pend_any, fill_any;
   logic [IDW-1:0]  hit_id, free_id, pend_id, fill_id;
   logic [MERGE_BITS-1:0] hit_cnt;
   logic            miss_acc, dram_acc, fill_acc;

   // Lookup and lowest-index selection, all from registered state
   always_comb begin
      hit      = 1'b0;
      hit_id   = '0;
      hit_cnt  = '0;
      fill_hit = 1'b0;
      free_any = 1'b0;
      free_id  = '0;
      pend_any = 1'b0;
      pend_id  = '0;
      fill_any = 1'b0;
      fill_id  = '0;
      for (int i = 0; i < ENTRIES; i++) begin
         if ((st_q[i] == S_PEND || st_q[i] == S_ISSUED) && addr_q[i] == i_miss_addr && !hit) begin
            hit     = 1'b1;
            hit_id  = IDW'(i);
            hit_cnt = cnt_q[i];
         end
         if (st_q[i] == S_FILL && addr_q[i] == i_miss_addr) fill_hit = 1'b1;
         if (st_q[i] == S_FREE && !free_any) begin
            free_any = 1'b1;
            free_id  = IDW'(i);
         end
         if (st_q[i] == S_PEND && !pend_any) begin
            pend_any = 1'b1;
            pend_id  = IDW'(i);
         end
         if (st_q[i] == S_FILL && !fill_any) begin
            fill_any = 1'b1;
            fill_id  = IDW'(i);
         end
      end
   end

   always_comb begin
      o_miss_ready = 1'b0;
      if (!i_reset && !fill_hit) o_miss_ready = hit ? (hit_cnt != CNT_MAX) : free_any;
   end

   assign o_miss_merged    = hit & ~i_reset;
   assign o_miss_id        = hit ? hit_id : free_id;
   assign o_dram_req_valid = pend_any & ~i_reset;
   assign o_dram_addr      = addr_q[pend_id];
   assign o_dram_id        = pend_id;
   assign o_dram_rsp_ready = 1'b1;
   assign o_fill_valid     = fill_any & ~i_reset;
   assign o_fill_addr      = addr_q[fill_id];
   assign o_fill_data      = data_q[fill_id];
   assign o_fill_count     = cnt_q[fill_id];

   assign miss_acc = i_miss_valid & o_miss_ready;
   assign dram_acc = o_dram_req_valid & i_dram_req_ready;
   assign fill_acc = o_fill_valid & i_fill_ready;

   // Per-entry next state; the four events always target distinct entries except
   // merge+issue and merge+response, which touch disjoint fields
   always_comb begin
      for (int i = 0; i < ENTRIES; i++) begin
         st_d[i]   = st_q[i];
         addr_d[i] = addr_q[i];
         data_d[i] = data_q[i];
         cnt_d[i]  = cnt_q[i];
      end
      if (dram_acc) st_d[pend_id] = S_ISSUED;
      if (i_dram_rsp_valid && st_q[i_dram_rid] == S_ISSUED) begin
         st_d[i_dram_rid]   = S_FILL;
         data_d[i_dram_rid] = i_dram_data;
      end
      if (miss_acc) begin
         if (hit) begin
            cnt_d[hit_id] = cnt_q[hit_id] + MERGE_BITS'(1);
         end else begin
            st_d[free_id]   = S_PEND;
            addr_d[free_id] = i_miss_addr;
            cnt_d[free_id]  = MERGE_BITS'(1);
         end
      end
      if (fill_acc) begin
         st_d[fill_id]  = S_FREE;
         cnt_d[fill_id] = '0;
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         for (int i = 0; i < ENTRIES; i++) begin
            st_q[i]   <= S_FREE;
            addr_q[i] <= '0;
            data_q[i] <= '0;
            cnt_q[i]  <= '0;
         end
      end else begin
         for (int i = 0; i < ENTRIES; i++) begin
            st_q[i]   <= st_d[i];
            addr_q[i] <= addr_d[i];
            data_q[i] <= data_d[i];
            cnt_q[i]  <= cnt_d[i];
         end
      end
   end

endmodule
